nn_img_loader: RTL and testbench



---
 rtl/nn_pkg.sv | 11 +
 rtl/nn_pix_addr_cnt.sv | 37 +++
 rtl/nn_img_loader.sv | 79 +++++++
 tb/tb_nn_img_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes and loader state type for the classifier datapath.
package nn_pkg;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int IMG_SIZE = IMG_W * IMG_H;
    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 10;
    localparam int HID_SIZE = 128;
    localparam int OUT_SIZE = 10;
    typedef enum logic [1:0] {IDLE, WAIT_SOF, LOAD, FULL} ld_state_t;
endpackage

// File: rtl/nn_pix_addr_cnt.sv
// nn_pix_addr_cnt: raster row/col counter holding the position of the next pixel.
module nn_pix_addr_cnt #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_clr,
    input  logic              i_restart,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
    logic [CW-1:0] r_col, w_col_b;
    logic [RW-1:0] r_row, w_row_b;
    logic          w_col_wrap;
    // a restart counts from pixel 0 and advances past it in the same cycle
    always_comb begin
        w_col_b    = i_restart ? '0 : r_col;
        w_row_b    = i_restart ? '0 : r_row;
        w_col_wrap = w_col_b == CW'(IMG_W - 1);
    end
    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_restart || i_inc) begin
            r_col <= w_col_wrap ? '0 : w_col_b + 1'b1;
            r_row <= !w_col_wrap ? w_row_b : (w_row_b == RW'(IMG_H - 1) ? '0 : w_row_b + 1'b1);
        end
    end
    assign o_addr = ADDR_W'(r_row) * ADDR_W'(IMG_W) + ADDR_W'(r_col);
    assign o_last = r_col == CW'(IMG_W - 1) && r_row == RW'(IMG_H - 1);
endmodule

// File: rtl/nn_img_loader.sv
// nn_img_loader: writes one raster-ordered pixel frame into the image RAM and
// holds finish_read until the inference engine acknowledges the frame.
module nn_img_loader import nn_pkg::*; #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    output logic              finish_read,
    input  logic              ack,
    output logic              err
);
    ld_state_t         r_state, w_next;
    logic              r_ready, r_we, r_fin, r_err;
    logic [ADDR_W-1:0] r_addr, w_cnt_addr;
    logic [PIX_W-1:0]  r_wdata;
    logic              w_acc, w_wr, w_last;

    assign w_acc = s_valid && r_ready;
    // in WAIT_SOF only the sof beat is written; everything before it is dropped
    assign w_wr  = w_acc && (r_state == LOAD || s_sof);

    nn_pix_addr_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .i_clr     (r_state == IDLE),
        .i_restart (w_wr && s_sof),
        .i_inc     (w_wr && !s_sof),
        .o_addr    (w_cnt_addr),
        .o_last    (w_last)
    );

    always_comb begin
        w_next = (r_state == IDLE && start)                      ? WAIT_SOF :
                 (r_state == WAIT_SOF && w_acc && s_sof)         ? LOAD :
                 (r_state == LOAD && w_wr && !s_sof && w_last)   ? FULL :
                 (r_state == FULL && ack)                        ? IDLE : r_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fin   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_next == WAIT_SOF || w_next == LOAD;
            r_we    <= w_wr;
            if (w_wr) begin
                r_addr  <= s_sof ? '0 : w_cnt_addr;
                r_wdata <= s_data;
            end
            // lags FULL by one cycle so it rises with the RAM capturing the last pixel
            r_fin   <= r_state == FULL && !ack;
            r_err   <= w_acc && s_sof && r_state == LOAD;
        end
    end

    assign s_ready     = r_ready;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign finish_read = r_fin;
    assign err         = r_err;
endmodule

// File: tb/tb_nn_img_loader.sv
// tb_nn_img_loader: randomized frame-level checks of nn_img_loader against a pixel-position model.
module tb_nn_img_loader;
    localparam int N = 784;
    logic       CLK = 1'b0, RST, start, s_valid, s_sof, ack;
    logic [7:0] s_data, mem_wdata;
    logic [9:0] mem_addr;
    logic       s_ready, mem_we, finish_read, err;
    int         total = 0, bad = 0;
    int         got_q[$], exp_q[$];
    int         we_cnt = 0, err_cnt = 0, err_w0 = 0, cyc = 0, last_we_cyc = -1, fin_rise_cyc = -1;
    int         m_pos = -1, m_err = 0;
    logic       fin_prev = 1'b0;
    logic [7:0] dut_ram [N], exp_ram [N];

    nn_img_loader dut (
        .CLK(CLK), .RST(RST), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .finish_read(finish_read), .ack(ack), .err(err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (mem_we) begin
            got_q.push_back(int'({mem_addr, mem_wdata}));
            if (mem_addr < 10'(N)) dut_ram[mem_addr] = mem_wdata;
            we_cnt++;
            if (mem_addr == 10'(N - 1)) last_we_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            if (mem_we && mem_addr == 10'd0) err_w0++;
        end
        if (finish_read && !fin_prev) fin_rise_cyc = cyc;
        fin_prev = finish_read;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        we_cnt = 0; err_cnt = 0; err_w0 = 0; last_we_cyc = -1; fin_rise_cyc = -1;
        m_pos = -1; m_err = 0;
    endtask

    // frame model: position -1 waits for sof, 0..N-1 loading, N holds a full frame
    task automatic model_beat(input logic [7:0] d, input logic sof);
        if (sof && m_pos < N) begin
            if (m_pos > 0) m_err++;
            exp_q.push_back(int'(d));
            exp_ram[0] = d;
            m_pos = 1;
        end else if (!sof && m_pos >= 0 && m_pos < N) begin
            exp_q.push_back(m_pos * 256 + int'(d));
            exp_ram[m_pos] = d;
            m_pos++;
        end
    endtask

    task automatic offer(input logic [7:0] d, input logic sof, input bit gaps);
        int n = 0;
        bit acc = 0;
        while (!acc) begin
            if (gaps && $urandom_range(99) < 30) begin
                s_valid = 1'b0; s_sof = 1'b0;
                tick();
            end
            s_valid = 1'b1; s_data = d; s_sof = sof;
            acc = s_ready;
            tick();
            if (!acc && ++n > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
                break;
            end
        end
        if (acc) model_beat(d, sof);
        s_valid = 1'b0; s_sof = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input bit rnd);
        for (int i = 0; i < N; i++) offer(rnd ? 8'($urandom) : 8'(i), i == 0, gaps);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_finish();
        for (int n = 0; n < 20 && !finish_read; n++) tick();
    endtask

    function automatic int q_diff();
        int d = got_q.size() > exp_q.size() ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic int ram_diff();
        int d = 0;
        for (int i = 0; i < N; i++) if (dut_ram[i] !== exp_ram[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", s_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %0b want 0", mem_we); end
        total++; if (mem_addr !== 10'd0) begin bad++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        total++; if (mem_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata: got %0d want 0", mem_wdata); end
        total++; if (finish_read !== 1'b0) begin bad++; $display("FAIL rst_finish: got %0b want 0", finish_read); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err); end
        RST = 1'b0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %0b want 0", s_ready); end
    endtask

    task automatic test_full_frame();
        clear_log();
        do_start();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL ready_after_start: got %0b want 1", s_ready); end
        send_frame(0, 0);
        total++; if (finish_read !== 1'b0) begin bad++; $display("FAIL finish_early: got %0b want 0", finish_read); end
        wait_finish();
        total++; if (finish_read !== 1'b1) begin bad++; $display("FAIL finish_set: got %0b want 1", finish_read); end
        total++; if (fin_rise_cyc - last_we_cyc !== 1) begin bad++; $display("FAIL finish_timing: got %0d want 1", fin_rise_cyc - last_we_cyc); end
        total++; if (q_diff() !== 0) begin bad++; $display("FAIL frame_writes: got %0d diffs want 0", q_diff()); end
        total++; if (we_cnt !== N) begin bad++; $display("FAIL frame_we_cnt: got %0d want %0d", we_cnt, N); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", s_ready); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL frame_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_full_hold();
        int we0 = we_cnt;
        bit rdy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_sof = 1'($urandom); s_data = 8'($urandom); start = k == 2;
            if (s_ready) rdy_seen = 1;
            tick();
        end
        s_valid = 1'b0; s_sof = 1'b0; start = 1'b0;
        tick();
        total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL hold_ready: got %0b want 0", rdy_seen); end
        total++; if (we_cnt !== we0) begin bad++; $display("FAIL hold_writes: got %0d want %0d", we_cnt, we0); end
        total++; if (finish_read !== 1'b1) begin bad++; $display("FAIL hold_finish: got %0b want 1", finish_read); end
        do_ack();
        total++; if (finish_read !== 1'b0) begin bad++; $display("FAIL ack_finish: got %0b want 0", finish_read); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ack_ready: got %0b want 0", s_ready); end
        do_start();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL restart_after_ack: got %0b want 1", s_ready); end
    endtask

    task automatic test_gaps();
        clear_log();
        send_frame(1, 1);
        wait_finish();
        total++; if (finish_read !== 1'b1) begin bad++; $display("FAIL gaps_finish: got %0b want 1", finish_read); end
        total++; if (ram_diff() !== 0) begin bad++; $display("FAIL gaps_ram: got %0d diffs want 0", ram_diff()); end
        total++; if (we_cnt !== N) begin bad++; $display("FAIL gaps_we_cnt: got %0d want %0d", we_cnt, N); end
        total++; if (q_diff() !== 0) begin bad++; $display("FAIL gaps_order: got %0d diffs want 0", q_diff()); end
        do_ack();
    endtask

    task automatic test_no_sof();
        clear_log();
        do_start();
        for (int i = 0; i < 5; i++) offer(8'($urandom), 1'b0, 0);
        tick();
        total++; if (we_cnt !== 0) begin bad++; $display("FAIL nosof_writes: got %0d want 0", we_cnt); end
        send_frame(0, 1);
        wait_finish();
        total++; if (q_diff() !== 0) begin bad++; $display("FAIL nosof_frame: got %0d diffs want 0", q_diff()); end
        total++; if (ram_diff() !== 0) begin bad++; $display("FAIL nosof_ram: got %0d diffs want 0", ram_diff()); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL nosof_err: got %0d want 0", err_cnt); end
        do_ack();
    endtask

    task automatic test_restart();
        clear_log();
        do_start();
        for (int i = 0; i < 300; i++) offer(8'($urandom), i == 0, 1);
        offer(8'($urandom), 1'b1, 0);
        for (int i = 1; i < N - 1; i++) offer(8'($urandom), 1'b0, 1);
        tick();
        total++; if (finish_read !== 1'b0) begin bad++; $display("FAIL restart_early: got %0b want 0", finish_read); end
        offer(8'($urandom), 1'b0, 0);
        wait_finish();
        total++; if (finish_read !== 1'b1) begin bad++; $display("FAIL restart_finish: got %0b want 1", finish_read); end
        total++; if (err_cnt !== m_err) begin bad++; $display("FAIL restart_err: got %0d want %0d", err_cnt, m_err); end
        total++; if (err_w0 !== 1) begin bad++; $display("FAIL restart_err_addr0: got %0d want 1", err_w0); end
        total++; if (q_diff() !== 0) begin bad++; $display("FAIL restart_writes: got %0d diffs want 0", q_diff()); end
        total++; if (we_cnt !== 300 + N) begin bad++; $display("FAIL restart_we_cnt: got %0d want %0d", we_cnt, 300 + N); end
        do_ack();
    endtask

    task automatic test_rst_mid();
        int we0;
        clear_log();
        do_start();
        for (int i = 0; i < 400; i++) offer(8'($urandom), i == 0, 0);
        RST = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
        tick();
        RST = 1'b0;
        total++; if ({s_ready, mem_we, finish_read, err} !== 4'b0) begin bad++; $display("FAIL rstmid_flags: got %b want 0000", {s_ready, mem_we, finish_read, err}); end
        total++; if ({mem_addr, mem_wdata} !== 18'd0) begin bad++; $display("FAIL rstmid_port: got addr=%0d data=%0d want 0/0", mem_addr, mem_wdata); end
        we0 = we_cnt;
        for (int k = 0; k < 3; k++) tick();
        s_valid = 1'b0;
        total++; if (we_cnt !== we0) begin bad++; $display("FAIL rstmid_no_we: got %0d want %0d", we_cnt, we0); end
        clear_log();
        do_start();
        send_frame(1, 1);
        wait_finish();
        total++; if (q_diff() !== 0) begin bad++; $display("FAIL rstmid_frame: got %0d diffs want 0", q_diff()); end
        total++; if (finish_read !== 1'b1) begin bad++; $display("FAIL rstmid_finish: got %0b want 1", finish_read); end
        do_ack();
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; s_valid = 1'b0; s_sof = 1'b0; ack = 1'b0; s_data = 8'd0;
        for (int i = 0; i < N; i++) begin dut_ram[i] = 8'd0; exp_ram[i] = 8'd0; end
        test_reset();
        test_full_frame();
        test_full_hold();
        test_gaps();
        test_no_sof();
        test_restart();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
